// File: rtl/multiport_register_file_pkg.sv
// rtl/multiport_register_file_pkg.sv - shared defaults and address-width helper for the register file
package multiport_register_file_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_NREG = 32;

  // Address bits needed to name nreg registers (nreg is at least 2).
  function automatic int rf_addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard with reservation-over-writeback priority
module regfile_scoreboard
  import multiport_register_file_pkg::*;
#(
  parameter int NREG   = DEFAULT_NREG,
  parameter int BYPASS = 1,
  localparam int AW    = rf_addr_width(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy_nxt,
  output logic          rs2_busy_nxt
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_view;

  // Writeback clears, then a same-edge reservation sets again so the newest producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (wr_en && (wr_addr == AW'(i))) busy_d[i] = 1'b0;
      if (rsv_en && (rsv_addr == AW'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector; reset drops any reservation still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Operand status lookup; out-of-range addresses never match and report not busy.
  always_comb begin
    busy_view    = (BYPASS != 0) ? busy_d : busy_q;
    rs1_busy_nxt = 1'b0;
    rs2_busy_nxt = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rs1_addr == AW'(i)) rs1_busy_nxt = busy_view[i];
      if (rs2_addr == AW'(i)) rs2_busy_nxt = busy_view[i];
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - 2-read/1-write register file with optional forwarding and scoreboard
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREG   = DEFAULT_NREG,
  parameter int BYPASS = 1,
  localparam int AW    = rf_addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rd_en,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            rs1_busy_q, rs1_busy_d;
  logic            rs2_busy_q, rs2_busy_d;
  logic            rs1_busy_nxt, rs2_busy_nxt;

  regfile_scoreboard #(
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy_nxt (rs1_busy_nxt),
    .rs2_busy_nxt (rs2_busy_nxt)
  );

  // Next register contents; x0 is hardwired and out-of-range writes match nothing.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 1; i < NREG; i++) begin
      if (wr_en && (wr_addr == AW'(i))) regs_d[i] = wr_data;
    end
    regs_d[0] = '0;
  end

  // Read operands from post-write contents when forwarding, else pre-write; hold when idle.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_busy_d = rs1_busy_q;
    rs2_busy_d = rs2_busy_q;
    if (rd_en) begin
      rs1_data_d = '0;
      rs2_data_d = '0;
      for (int i = 0; i < NREG; i++) begin
        if (rs1_addr == AW'(i)) rs1_data_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        if (rs2_addr == AW'(i)) rs2_data_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
      end
      rs1_busy_d = rs1_busy_nxt;
      rs2_busy_d = rs2_busy_nxt;
    end
  end

  // Storage array and registered read outputs, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rs1_busy = rs1_busy_q;
  assign rs2_busy = rs2_busy_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - self-checking bench for forwarding and non-forwarding register files
module tb_multiport_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;

  logic [63:0] rs1_data_0, rs2_data_0, rs1_data_1, rs2_data_1;
  logic        rs1_busy_0, rs2_busy_0, rs1_busy_1, rs2_busy_1;

  int n_asserts = 0;
  int n_fail = 0;

  // Instance 0: forwarding, 32 registers. Instance 1: no forwarding, 24 registers (x24..x31 absent).
  localparam int NR0 = 32;
  localparam int NR1 = 24;

  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];
  logic [63:0] e_d1 [2];
  logic [63:0] e_d2 [2];
  bit          e_b1 [2];
  bit          e_b2 [2];

  always #5 clk = ~clk;

  multiport_register_file #(.XLEN(64), .NREG(NR0), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_en(rd_en),
    .rs1_data(rs1_data_0), .rs2_data(rs2_data_0), .rs1_busy(rs1_busy_0), .rs2_busy(rs2_busy_0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  multiport_register_file #(.XLEN(64), .NREG(NR1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_en(rd_en),
    .rs1_data(rs1_data_1), .rs2_data(rs2_data_1), .rs1_busy(rs1_busy_1), .rs2_busy(rs2_busy_1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("byp.rs1_data", rs1_data_0, e_d1[0]);
    chk("byp.rs2_data", rs2_data_0, e_d2[0]);
    chk("byp.rs1_busy", {63'b0, rs1_busy_0}, {63'b0, e_b1[0]});
    chk("byp.rs2_busy", {63'b0, rs2_busy_0}, {63'b0, e_b2[0]});
    chk("nobyp.rs1_data", rs1_data_1, e_d1[1]);
    chk("nobyp.rs2_data", rs2_data_1, e_d2[1]);
    chk("nobyp.rs1_busy", {63'b0, rs1_busy_1}, {63'b0, e_b1[1]});
    chk("nobyp.rs2_busy", {63'b0, rs2_busy_1}, {63'b0, e_b2[1]});
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[c][k]  = '0;
        m_busy[c][k] = 1'b0;
      end
      e_d1[c] = '0; e_d2[c] = '0; e_b1[c] = 1'b0; e_b2[c] = 1'b0;
    end
  endtask

  // Architectural effect of one rising edge, evaluated from the rules of the register file.
  task automatic model_edge();
    logic [63:0] nm [32];
    bit          nb [32];
    int          n;
    bit          byp;
    int          a1, a2, wa, ra;
    a1 = int'(rs1_addr); a2 = int'(rs2_addr); wa = int'(wr_addr); ra = int'(rsv_addr);
    for (int c = 0; c < 2; c++) begin
      n   = (c == 0) ? NR0 : NR1;
      byp = (c == 0);
      for (int k = 0; k < 32; k++) begin
        nm[k] = m_mem[c][k];
        nb[k] = m_busy[c][k];
      end
      if (wr_en && wa != 0 && wa < n) nm[wa] = wr_data;
      if (wr_en && wa != 0 && wa < n) nb[wa] = 1'b0;
      if (rsv_en && ra != 0 && ra < n) nb[ra] = 1'b1;
      if (rd_en) begin
        e_d1[c] = (a1 >= n) ? 64'd0 : (byp ? nm[a1] : m_mem[c][a1]);
        e_d2[c] = (a2 >= n) ? 64'd0 : (byp ? nm[a2] : m_mem[c][a2]);
        e_b1[c] = (a1 >= n) ? 1'b0 : (byp ? nb[a1] : m_busy[c][a1]);
        e_b2[c] = (a2 >= n) ? 1'b0 : (byp ? nb[a2] : m_busy[c][a2]);
      end
      for (int k = 0; k < 32; k++) begin
        m_mem[c][k]  = nm[k];
        m_busy[c][k] = nb[k];
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, then check at the next falling edge.
  task automatic cyc(input bit rd, input logic [4:0] a1, input logic [4:0] a2,
                     input bit we, input logic [4:0] wa, input logic [63:0] wd,
                     input bit re, input logic [4:0] ra);
    rd_en = rd; rs1_addr = a1; rs2_addr = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [4:0] r1, r2, wa, ra;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Freshly reset file reads zero and not busy.
    cyc(1, 5'd5, 5'd7, 0, 5'd0, 64'd0, 0, 5'd0);

    // Same-edge write and read of x3, then re-read.
    cyc(1, 5'd3, 5'd0, 1, 5'd3, 64'hDEADBEEF_00000001, 0, 5'd0);
    cyc(1, 5'd3, 5'd3, 0, 5'd0, 64'd0, 0, 5'd0);

    // x0 ignores writes and reservations.
    cyc(1, 5'd0, 5'd0, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd0);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 64'd0, 0, 5'd0);

    // Scoreboard: reserve, write+reserve keeps busy, plain write clears.
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd9);
    cyc(1, 5'd0, 5'd9, 0, 5'd0, 64'd0, 0, 5'd0);
    cyc(1, 5'd9, 5'd9, 1, 5'd9, 64'h42, 1, 5'd9);
    cyc(1, 5'd9, 5'd9, 0, 5'd0, 64'd0, 0, 5'd0);
    cyc(1, 5'd0, 5'd9, 1, 5'd9, 64'h42, 0, 5'd0);
    cyc(1, 5'd0, 5'd9, 0, 5'd0, 64'd0, 0, 5'd0);

    // Out-of-range register for the 24-entry file.
    cyc(1, 5'd30, 5'd0, 1, 5'd30, 64'h1234_5678_9ABC_DEF0, 1, 5'd30);
    cyc(1, 5'd30, 5'd30, 0, 5'd0, 64'd0, 0, 5'd0);

    // Hold with rd_en low, then asynchronous reset between edges with a reservation in flight.
    cyc(1, 5'd4, 5'd4, 1, 5'd4, 64'h55, 1, 5'd12);
    cyc(0, 5'd17, 5'd2, 0, 5'd0, 64'd0, 0, 5'd0);
    cyc(0, 5'd12, 5'd4, 0, 5'd0, 64'd0, 1, 5'd13);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc(1, 5'd4, 5'd12, 1, 5'd4, 64'h77, 1, 5'd4);
    rst_n = 1'b1;
    cyc(1, 5'd4, 5'd13, 0, 5'd0, 64'd0, 0, 5'd0);
    cyc(1, 5'd12, 5'd4, 0, 5'd0, 64'd0, 0, 5'd0);

    // Randomized traffic biased toward a few addresses so collisions are common.
    for (int t = 0; t < 400; t++) begin
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? ra : (($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31)));
      cyc(($urandom_range(0, 4) != 0), r1, r2,
          ($urandom_range(0, 1) == 1), wa, {$urandom, $urandom},
          ($urandom_range(0, 2) == 0), ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
